// File: rtl/vx_decode_gpr_if_pkg.sv
// Shared parameters, encodings and helpers for the operand-fetch stage.
package vx_decode_gpr_if_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NW_BITS     = 2;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 5;
  localparam int PERF_W      = 44;
  localparam int DATA_W      = NUM_THREADS * XLEN;

  // Execute-unit select, shared with the decoder and dispatcher.
  typedef enum logic [2:0] {
    EX_NOP = 3'd0,
    EX_ALU = 3'd1,
    EX_LSU = 3'd2,
    EX_CSR = 3'd3,
    EX_FPU = 3'd4,
    EX_GPU = 3'd5
  } ex_type_e;

  // Opcode encoding within a unit.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_LUI  = 4'd7,
    OP_LOAD = 4'd8,
    OP_STOR = 4'd9
  } op_type_e;

  // Instruction fields carried through the stage register.
  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [2:0]             ex_type;
    logic [3:0]             op_type;
    logic [2:0]             op_mod;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [31:0]            imm;
    logic                   use_pc;
    logic                   use_imm;
  } instr_t;

  // Number of active lanes in a thread mask, sized for the perf counter.
  function automatic logic [PERF_W-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
    logic [PERF_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + PERF_W'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_decode_gpr_if_if.sv
// Bus bundle for the operand-fetch stage: decode input, register-file
// request/response, execute output and perf counters.
// Handshakes (dec_*, out_*): a transfer happens on a rising edge where
// valid && ready; the sender keeps payload stable while valid && !ready.
interface vx_decode_gpr_if_if
  import vx_decode_gpr_if_pkg::*;
  ;

  logic                   dec_valid;
  logic                   dec_ready;
  logic [NW_BITS-1:0]     dec_wid;
  logic [NUM_THREADS-1:0] dec_tmask;
  logic [31:0]            dec_PC;
  logic [2:0]             dec_ex_type;
  logic [3:0]             dec_op_type;
  logic [2:0]             dec_op_mod;
  logic                   dec_wb;
  logic [NR_BITS-1:0]     dec_rd;
  logic [NR_BITS-1:0]     dec_rs1;
  logic [NR_BITS-1:0]     dec_rs2;
  logic [NR_BITS-1:0]     dec_rs3;
  logic [31:0]            dec_imm;
  logic                   dec_use_PC;
  logic                   dec_use_imm;
  logic                   delay;

  logic [NW_BITS-1:0]     gpr_req_wid;
  logic [NR_BITS-1:0]     gpr_req_rs1;
  logic [NR_BITS-1:0]     gpr_req_rs2;
  logic [NR_BITS-1:0]     gpr_req_rs3;
  logic [DATA_W-1:0]      gpr_rsp_rs1_data;
  logic [DATA_W-1:0]      gpr_rsp_rs2_data;
  logic [DATA_W-1:0]      gpr_rsp_rs3_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [NW_BITS-1:0]     out_wid;
  logic [NUM_THREADS-1:0] out_tmask;
  logic [31:0]            out_PC;
  logic [2:0]             out_ex_type;
  logic [3:0]             out_op_type;
  logic [2:0]             out_op_mod;
  logic                   out_wb;
  logic [NR_BITS-1:0]     out_rd;
  logic [NR_BITS-1:0]     out_rs1;
  logic [31:0]            out_imm;
  logic                   out_use_PC;
  logic                   out_use_imm;
  logic [DATA_W-1:0]      out_rs1_data;
  logic [DATA_W-1:0]      out_rs2_data;
  logic [DATA_W-1:0]      out_rs3_data;

  logic [PERF_W-1:0]      perf_scb_stalls;
  logic [PERF_W-1:0]      perf_active_threads;

  // Environment side: decoder, register file, dispatcher.
  modport master (
    output dec_valid, dec_wid, dec_tmask, dec_PC, dec_ex_type, dec_op_type,
           dec_op_mod, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_imm,
           dec_use_PC, dec_use_imm, delay,
           gpr_rsp_rs1_data, gpr_rsp_rs2_data, gpr_rsp_rs3_data, out_ready,
    input  dec_ready, gpr_req_wid, gpr_req_rs1, gpr_req_rs2, gpr_req_rs3,
           out_valid, out_wid, out_tmask, out_PC, out_ex_type, out_op_type,
           out_op_mod, out_wb, out_rd, out_rs1, out_imm, out_use_PC,
           out_use_imm, out_rs1_data, out_rs2_data, out_rs3_data,
           perf_scb_stalls, perf_active_threads
  );

  // Stage side.
  modport slave (
    input  dec_valid, dec_wid, dec_tmask, dec_PC, dec_ex_type, dec_op_type,
           dec_op_mod, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3, dec_imm,
           dec_use_PC, dec_use_imm, delay,
           gpr_rsp_rs1_data, gpr_rsp_rs2_data, gpr_rsp_rs3_data, out_ready,
    output dec_ready, gpr_req_wid, gpr_req_rs1, gpr_req_rs2, gpr_req_rs3,
           out_valid, out_wid, out_tmask, out_PC, out_ex_type, out_op_type,
           out_op_mod, out_wb, out_rd, out_rs1, out_imm, out_use_PC,
           out_use_imm, out_rs1_data, out_rs2_data, out_rs3_data,
           perf_scb_stalls, perf_active_threads
  );

endinterface

// File: rtl/vx_decode_gpr_if_operand_hold.sv
// Operand capture: passes the register-file response through in the cycle
// after an accept and keeps a copy so stalled outputs stay stable.
module vx_operand_hold
  import vx_decode_gpr_if_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] rsp_rs1_i,
  input  logic [DATA_W-1:0] rsp_rs2_i,
  input  logic [DATA_W-1:0] rsp_rs3_i,
  output logic [DATA_W-1:0] data_rs1_o,
  output logic [DATA_W-1:0] data_rs2_o,
  output logic [DATA_W-1:0] data_rs3_o
);

  logic              fresh_q, fresh_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic [DATA_W-1:0] hold2_q, hold2_d;
  logic [DATA_W-1:0] hold3_q, hold3_d;

  // Next state: fresh only in the cycle right after an accept; the hold
  // registers sample the response during that fresh cycle.
  always_comb begin
    fresh_d = accept_i;
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    hold3_d = hold3_q;
    if (fresh_q) begin
      hold1_d = rsp_rs1_i;
      hold2_d = rsp_rs2_i;
      hold3_d = rsp_rs3_i;
    end
  end

  // Fresh flag and hold registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fresh_q <= 1'b0;
      hold1_q <= '0;
      hold2_q <= '0;
      hold3_q <= '0;
    end else begin
      fresh_q <= fresh_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
      hold3_q <= hold3_d;
    end
  end

  // Output mux: live response while fresh, captured copy afterwards.
  always_comb begin
    data_rs1_o = fresh_q ? rsp_rs1_i : hold1_q;
    data_rs2_o = fresh_q ? rsp_rs2_i : hold2_q;
    data_rs3_o = fresh_q ? rsp_rs3_i : hold3_q;
  end

endmodule

// File: rtl/vx_decode_gpr_if.sv
// Operand-fetch stage: issues the register read from the incoming decoded
// instruction, registers the instruction, pairs it with the read response
// one cycle later and keeps scoreboard-stall / active-thread counters.
module vx_decode_gpr_if
  import vx_decode_gpr_if_pkg::*;
(
  input  logic clk,
  input  logic reset,
  vx_decode_gpr_if_if.slave bus
);

  instr_t            dec_instr;
  instr_t            instr_q, instr_d;
  logic              out_valid_q, out_valid_d;
  logic [PERF_W-1:0] scb_stalls_q, scb_stalls_d;
  logic [PERF_W-1:0] active_q, active_d;
  logic              dec_ready;
  logic              accept;

  // Pack the decode fields and form the acceptance condition.
  always_comb begin
    dec_instr.wid     = bus.dec_wid;
    dec_instr.tmask   = bus.dec_tmask;
    dec_instr.pc      = bus.dec_PC;
    dec_instr.ex_type = bus.dec_ex_type;
    dec_instr.op_type = bus.dec_op_type;
    dec_instr.op_mod  = bus.dec_op_mod;
    dec_instr.wb      = bus.dec_wb;
    dec_instr.rd      = bus.dec_rd;
    dec_instr.rs1     = bus.dec_rs1;
    dec_instr.imm     = bus.dec_imm;
    dec_instr.use_pc  = bus.dec_use_PC;
    dec_instr.use_imm = bus.dec_use_imm;
    // A scoreboard hazard blocks acceptance; otherwise accept whenever the
    // stage is empty or draining this cycle (no bubble on back-to-back).
    dec_ready = !bus.delay && (!out_valid_q || bus.out_ready);
    accept    = bus.dec_valid && dec_ready;
  end

  // Next state of the stage register and perf counters.
  always_comb begin
    instr_d      = instr_q;
    out_valid_d  = out_valid_q;
    active_d     = active_q;
    scb_stalls_d = scb_stalls_q;
    if (accept) begin
      instr_d     = dec_instr;
      out_valid_d = 1'b1;
      active_d    = popcount(bus.dec_tmask);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.dec_valid && bus.delay) begin
      scb_stalls_d = scb_stalls_q + 1'b1;
    end
  end

  // Stage register and counters, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q      <= '0;
      out_valid_q  <= 1'b0;
      active_q     <= '0;
      scb_stalls_q <= '0;
    end else begin
      instr_q      <= instr_d;
      out_valid_q  <= out_valid_d;
      active_q     <= active_d;
      scb_stalls_q <= scb_stalls_d;
    end
  end

  vx_operand_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .accept_i   (accept),
    .rsp_rs1_i  (bus.gpr_rsp_rs1_data),
    .rsp_rs2_i  (bus.gpr_rsp_rs2_data),
    .rsp_rs3_i  (bus.gpr_rsp_rs3_data),
    .data_rs1_o (bus.out_rs1_data),
    .data_rs2_o (bus.out_rs2_data),
    .data_rs3_o (bus.out_rs3_data)
  );

  // Register-file request straight from the decode inputs, plus outputs.
  always_comb begin
    bus.gpr_req_wid         = bus.dec_wid;
    bus.gpr_req_rs1         = bus.dec_rs1;
    bus.gpr_req_rs2         = bus.dec_rs2;
    bus.gpr_req_rs3         = bus.dec_rs3;
    bus.dec_ready           = dec_ready;
    bus.out_valid           = out_valid_q;
    bus.out_wid             = instr_q.wid;
    bus.out_tmask           = instr_q.tmask;
    bus.out_PC              = instr_q.pc;
    bus.out_ex_type         = instr_q.ex_type;
    bus.out_op_type         = instr_q.op_type;
    bus.out_op_mod          = instr_q.op_mod;
    bus.out_wb              = instr_q.wb;
    bus.out_rd              = instr_q.rd;
    bus.out_rs1             = instr_q.rs1;
    bus.out_imm             = instr_q.imm;
    bus.out_use_PC          = instr_q.use_pc;
    bus.out_use_imm         = instr_q.use_imm;
    bus.perf_scb_stalls     = scb_stalls_q;
    bus.perf_active_threads = active_q;
  end

endmodule

// File: tb/tb_vx_decode_gpr_if.sv
// Directed bench for the operand-fetch stage.
module tb_vx_decode_gpr_if;
  import vx_decode_gpr_if_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  vx_decode_gpr_if_if bus ();

  vx_decode_gpr_if dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rep(input logic [31:0] x);
    return {NUM_THREADS{x}};
  endfunction

  // Driver tasks
  task automatic drive_dec(input logic [NW_BITS-1:0] wid, input logic [3:0] tmask,
                           input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rs3);
    bus.dec_valid   = 1'b1;
    bus.dec_wid     = wid;
    bus.dec_tmask   = tmask;
    bus.dec_PC      = pc;
    bus.dec_ex_type = 3'd1;
    bus.dec_op_type = 4'd2;
    bus.dec_op_mod  = 3'd0;
    bus.dec_wb      = 1'b1;
    bus.dec_rd      = 5'd9;
    bus.dec_rs1     = rs1;
    bus.dec_rs2     = rs2;
    bus.dec_rs3     = rs3;
    bus.dec_imm     = pc ^ 32'h5A5A_0000;
    bus.dec_use_PC  = 1'b0;
    bus.dec_use_imm = 1'b1;
  endtask

  task automatic set_rsp(input logic [31:0] base);
    bus.gpr_rsp_rs1_data = rep(base + 32'h1);
    bus.gpr_rsp_rs2_data = rep(base + 32'h2);
    bus.gpr_rsp_rs3_data = rep(base + 32'h3);
  endtask

  task automatic idle();
    bus.dec_valid = 1'b0;
    bus.delay     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_dec(2'd1, 4'b1111, 32'hDEAD_0000, 5'd1, 5'd2, 5'd3);
    bus.dec_valid = 1'b0;
    bus.delay     = 1'b0;
    bus.out_ready = 1'b1;
    set_rsp(32'hFFFF_0000);
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    vectors++;
    if (bus.out_PC !== 32'h0 || bus.out_rs1_data !== '0 || bus.perf_scb_stalls !== '0
        || bus.perf_active_threads !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got pc=%h rs1d=%h scb=%0d act=%0d exp all 0",
               bus.out_PC, bus.out_rs1_data, bus.perf_scb_stalls, bus.perf_active_threads);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    // At negedge: present instruction, check the combinational request.
    drive_dec(2'd2, 4'b1011, 32'h0000_0100, 5'd5, 5'd6, 5'd7);
    #1;
    vectors++;
    if ({bus.gpr_req_wid, bus.gpr_req_rs1, bus.gpr_req_rs2, bus.gpr_req_rs3}
        !== {2'd2, 5'd5, 5'd6, 5'd7}) begin
      miscompares++;
      $display("FAIL basic_gpr_req got (%0d,%0d,%0d,%0d) exp (2,5,6,7)",
               bus.gpr_req_wid, bus.gpr_req_rs1, bus.gpr_req_rs2, bus.gpr_req_rs3);
    end
    vectors++;
    if (bus.dec_ready !== 1'b1) begin
      miscompares++; $display("FAIL basic_dec_ready got %b exp 1", bus.dec_ready);
    end
    @(posedge clk); #1;
    bus.dec_valid = 1'b0;
    set_rsp(32'hA000_0000);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_PC !== 32'h100 || bus.out_wid !== 2'd2
        || bus.out_rs1 !== 5'd5 || bus.out_tmask !== 4'b1011) begin
      miscompares++;
      $display("FAIL basic_out got v=%b pc=%h wid=%0d rs1=%0d tm=%b exp v=1 pc=100 wid=2 rs1=5 tm=1011",
               bus.out_valid, bus.out_PC, bus.out_wid, bus.out_rs1, bus.out_tmask);
    end
    vectors++;
    if (bus.out_rs1_data !== rep(32'hA000_0001) || bus.out_rs2_data !== rep(32'hA000_0002)
        || bus.out_rs3_data !== rep(32'hA000_0003)) begin
      miscompares++;
      $display("FAIL basic_operands got %h %h %h exp A0000001/2/3 per lane",
               bus.out_rs1_data, bus.out_rs2_data, bus.out_rs3_data);
    end
    vectors++;
    if (bus.perf_active_threads !== 44'd3) begin
      miscompares++; $display("FAIL basic_active got %0d exp 3", bus.perf_active_threads);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_drain got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_dec(2'd1, 4'b0011, 32'h0000_0200, 5'd10, 5'd11, 5'd12);
    @(posedge clk); #1;
    // Next instruction waits while the first one is held.
    drive_dec(2'd3, 4'b1111, 32'h0000_0204, 5'd13, 5'd14, 5'd15);
    set_rsp(32'hB000_0000);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== rep(32'hB000_0001)) begin
      miscompares++;
      $display("FAIL bp_first got v=%b rs1d=%h exp v=1 B0000001", bus.out_valid, bus.out_rs1_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_rsp(32'hC000_0000 + 32'(i) * 32'h100);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_PC !== 32'h200 || bus.dec_ready !== 1'b0
          || bus.out_rs1_data !== rep(32'hB000_0001) || bus.out_rs3_data !== rep(32'hB000_0003)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b pc=%h rdy=%b rs1d=%h rs3d=%h exp v=1 pc=200 rdy=0 B0000001 B0000003",
                 i, bus.out_valid, bus.out_PC, bus.dec_ready, bus.out_rs1_data, bus.out_rs3_data);
      end
    end
    bus.dec_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.dec_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release_ready got %b exp 1", bus.dec_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_done got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  masks[4];
    logic [43:0] counts[4];
    masks  = '{4'b0000, 4'b1111, 4'b0110, 4'b1000};
    counts = '{44'd0, 44'd4, 44'd2, 44'd1};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_dec(2'(i), masks[i], 32'h300 + 32'(i) * 32'h4, 5'(i + 1), 5'(i + 2), 5'(i + 3));
      @(posedge clk); #1;
      set_rsp(32'hD000_0000 + 32'(i) * 32'h10);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_PC !== 32'h300 + 32'(i) * 32'h4
          || bus.out_rs1_data !== rep(32'hD000_0001 + 32'(i) * 32'h10)
          || bus.perf_active_threads !== counts[i]) begin
        miscompares++;
        $display("FAIL b2b[%0d] got v=%b pc=%h rs1d=%h act=%0d exp v=1 pc=%h act=%0d",
                 i, bus.out_valid, bus.out_PC, bus.out_rs1_data, bus.perf_active_threads,
                 32'h300 + 32'(i) * 32'h4, counts[i]);
      end
    end
    bus.dec_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_scoreboard();
    drive_dec(2'd0, 4'b0001, 32'h0000_0400, 5'd1, 5'd1, 5'd1);
    bus.delay = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.dec_ready !== 1'b0) begin
        miscompares++; $display("FAIL scb_ready[%0d] got %b exp 0", i, bus.dec_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL scb_out_valid[%0d] got %b exp 0", i, bus.out_valid);
      end
    end
    vectors++;
    if (bus.perf_scb_stalls !== 44'd5) begin
      miscompares++; $display("FAIL scb_count got %0d exp 5", bus.perf_scb_stalls);
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive_dec(2'd3, 4'b1111, 32'h0000_0500, 5'd2, 5'd3, 5'd4);
    @(posedge clk); #1;
    set_rsp(32'hE000_0000);
    bus.delay = 1'b1;   // stall the next instruction behind a held output
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.perf_scb_stalls !== 44'd6 || bus.perf_active_threads !== 44'd4) begin
      miscompares++;
      $display("FAIL arst_pre got v=%b scb=%0d act=%0d exp v=1 scb=6 act=4",
               bus.out_valid, bus.perf_scb_stalls, bus.perf_active_threads);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.perf_scb_stalls !== '0 || bus.perf_active_threads !== '0
        || bus.out_PC !== 32'h0 || bus.out_rs1_data !== '0) begin
      miscompares++;
      $display("FAIL arst_clear got v=%b scb=%0d act=%0d pc=%h rs1d=%h exp all 0",
               bus.out_valid, bus.perf_scb_stalls, bus.perf_active_threads, bus.out_PC, bus.out_rs1_data);
    end
    idle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    drive_dec(2'd1, 4'b0101, 32'h0000_0600, 5'd7, 5'd8, 5'd9);
    @(posedge clk); #1;
    bus.dec_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_PC !== 32'h600 || bus.perf_active_threads !== 44'd2) begin
      miscompares++;
      $display("FAIL arst_first_accept got v=%b pc=%h act=%0d exp v=1 pc=600 act=2",
               bus.out_valid, bus.out_PC, bus.perf_active_threads);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_scoreboard();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_decode_gpr_if.md
# vx_decode_gpr_if

Operand-fetch stage between the instruction buffer and the execute dispatcher. It accepts one decoded warp instruction per cycle over a valid/ready handshake and drives the register-file read request (wid, rs1, rs2, rs3) from the incoming instruction. It pairs the one-cycle-later register-file response with the registered instruction fields and presents the operand-complete instruction downstream. It also keeps the scoreboard-stall counter and the active-thread count of the last issue.

## Interface
- NUM_THREADS, 4, lanes per warp; tmask width.
- NW_BITS, 2, warp-id width.
- XLEN, 32, data width per lane.
- NR_BITS, 5, register index width.
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid / dec_ready  in / out  1 / 1  decode handshake.
- dec_wid, dec_tmask, dec_PC  in  NW_BITS, NUM_THREADS, 32  warp id, thread mask, PC.
- dec_ex_type, dec_op_type, dec_op_mod  in  3, 4, 3  unit select, opcode, modifier.
- dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3  in  1, NR_BITS ×4  writeback flag and register indices.
- dec_imm, dec_use_PC, dec_use_imm  in  32, 1, 1  immediate and operand selects.
- delay  in  1  scoreboard hazard; blocks acceptance.
- gpr_req_wid, gpr_req_rs1/rs2/rs3  out  NW_BITS, NR_BITS ×3  register-file read address.
- gpr_rsp_rs1/rs2/rs3_data  in  NUM_THREADS*XLEN each  register-file read data.
- out_valid / out_ready  out / in  1 / 1  execute handshake.
- out_* (wid, tmask, PC, ex_type, op_type, op_mod, wb, rd, rs1, imm, use_PC, use_imm)  out  same widths as dec_*.
- out_rs1/rs2/rs3_data  out  NUM_THREADS*XLEN each  operands.
- perf_scb_stalls  out  44  cycles with dec_valid && delay.
- perf_active_threads  out  44  popcount of tmask of the last accepted instruction.

## Operation
- gpr_req_* = dec_wid/rs1/rs2/rs3, purely combinational, every cycle.
- dec_ready = !delay && (!out_valid || out_ready). Accept = dec_valid && dec_ready.
- On accept, all dec_* fields are registered into out_*, out_valid <= 1, fresh <= 1.
- If there is no accept and out_ready is high, out_valid <= 0.
- Operand data:
  - While fresh = 1, out_rsX_data = gpr_rsp_rsX_data (pass-through) and the same value is latched into the hold registers.
  - While fresh = 0, out_rsX_data = hold.
  - fresh clears on the next clock edge without an accept.
- An accept in the same cycle as an output transfer replaces the stage with no bubble.
- perf_scb_stalls increments by 1 each cycle dec_valid && delay, wrapping at 2^44.
- perf_active_threads is loaded on accept with the count of set tmask bits (0..NUM_THREADS) and holds otherwise.

## Timing
- The register file has 1-cycle read latency. Request is in cycle t (accept), response in t+1, which is also the first cycle out_valid = 1.
- Accept-to-out latency: 1 cycle. Throughput: 1 instruction/cycle when out_ready stays high.
- out_* and operands stay stable while out_valid && !out_ready.
- delay high: dec_ready = 0 in the same cycle, with no effect on a held output.
- Reset (async, low) forces the following to 0 immediately, and also mid-transfer:
  - out_valid, fresh, all out_* registers, hold registers, perf_scb_stalls, perf_active_threads.
- The first accept is allowed on the first edge after reset deasserts.

## Structure
- Shared package: NUM_THREADS, NW_BITS, NR_BITS, XLEN, and the ex_type / op_type encodings used by the decoder and dispatcher.
- Submodule vx_operand_hold: fresh flag plus the 3 × NUM_THREADS*XLEN hold registers and the output mux.
- The top level holds the pipeline register, the handshake and the perf counters.

## Test plan
- Reset, then dec_valid=1, wid=2, rs1=5, rs2=6, rs3=7, tmask=4'b1011, out_ready=1:
  - gpr_req = (2,5,6,7) in the same cycle.
  - Next cycle out_valid=1 with out_rs1_data equal to the gpr_rsp value, and perf_active_threads=3.
- Back-pressure: hold out_ready=0 for 3 cycles while changing gpr_rsp each cycle:
  - out_rsX_data stays at the first-cycle response.
  - dec_ready=0.
  - Transfer completes when out_ready=1.
- Back-to-back: 4 instructions on consecutive cycles with out_ready=1 -> 4 consecutive out_valid cycles in order with matching PCs, no bubble.
- Scoreboard: dec_valid=1, delay=1 for 5 cycles -> dec_ready=0 throughout, perf_scb_stalls=5, out_valid stays 0.
- Async reset: assert reset=0 mid-stall with out_valid=1 -> out_valid and counters read 0 before the next clock edge.
